// File: rtl/fifo_rd_ctrl_pkg.sv
// fifo_rd_ctrl_pkg: shared FSM state type and sizing constants for the FIFO read-side burst controller
package fifo_rd_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  localparam int BUF_DEPTH = 2;
  localparam int STAT_WIDTH = 32;
  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: 2-entry in-order buffer; ports clk, reset (async high), push/push_data (tail write), pop (head release), head (oldest entry), count (occupancy)
module fifo_rd_skid_buf
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic [CNT_WIDTH-1:0] count
);
  logic [W-1:0] tail;
  logic [CNT_WIDTH-1:0] wr_idx;
  assign wr_idx = count - CNT_WIDTH'(pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= push && wr_idx == 0 ? push_data : pop ? tail : head;
      tail  <= push && wr_idx == 1 ? push_data : tail;
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: pops burst_len words from a FIFO read port into a valid/ready stream; ports clk, reset (async high), start/burst_len/busy/done (command), fifo_empty/fifo_almost_empty/fifo_data/rd_en (FIFO read port), m_valid/m_ready/m_data/m_last (stream); FIFO_RD_CTRL_STATS_EN adds pop_count/stall_cycles
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_RD_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] pop_count,
  output logic [STAT_WIDTH-1:0] stall_cycles
`endif
);
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] buf_count;
  logic [DATA_WIDTH:0] head;
  logic pop, last_pop, accept;
  assign pop = m_valid && m_ready;
  assign {m_last, m_data} = head;
  assign m_valid = buf_count != 0;
  assign busy = state != IDLE;
  assign last_pop = remaining == LEN_WIDTH'(1);
  assign accept = state == IDLE && start && burst_len != 0;
  always_comb begin
    rd_en = state == FETCH && !fifo_empty && !fifo_almost_empty && buf_count < CNT_WIDTH'(BUF_DEPTH);
    state_nxt = accept ? FETCH
      : state == FETCH && rd_en && last_pop ? FLUSH
      : state == FLUSH && pop && m_last ? IDLE
      : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= accept ? burst_len : rd_en ? remaining - LEN_WIDTH'(1) : remaining;
      done      <= state == FLUSH && pop && m_last;
    end
  end
  fifo_rd_skid_buf #(.W(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_en),
    .push_data ({last_pop, fifo_data}),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );
`ifdef FIFO_RD_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count    <= '0;
      stall_cycles <= '0;
    end else begin
      pop_count    <= pop_count + STAT_WIDTH'(rd_en && !(&pop_count));
      stall_cycles <= stall_cycles + STAT_WIDTH'(m_valid && !m_ready && !(&stall_cycles));
    end
  end
`endif
endmodule
